// File: rtl/ma3_pkg.sv
// Shared types and helpers for the 3-tap moving-sum stimulus/checker and its reference model.
package ma3_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned IDX_W    = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        WAIT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Galois mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
    localparam logic [SAMPLE_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [IDX_W-1:0]    IDX_NONE  = 16'hFFFF;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        sample_t          exp;
    } chk_t;

    // Three-tap sum with two's-complement wrap in the sample width
    function automatic sample_t ma3_sum(sample_t a, sample_t b, sample_t c);
        return a + b + c;
    endfunction

    function automatic logic [SAMPLE_W-1:0] lfsr_step(logic [SAMPLE_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/ma3_delay_line.sv
// Valid+data shift register aligning expected values with DUT latency; DEPTH=0 is a wire.
module ma3_delay_line #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_valid      = in_valid;
        assign out_data       = in_data;
    end else begin : g_shift
        logic [DEPTH-1:0] vld_q;
        logic [W-1:0]     dat_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                vld_q[0] <= in_valid;
                dat_q[0] <= in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign out_valid = vld_q[DEPTH-1];
        assign out_data  = dat_q[DEPTH-1];
    end

endmodule

// File: rtl/moving_average3_stim_check.sv
// Self-contained stimulus source and checker for a 3-tap moving-sum DUT:
// drives an LFSR sample stream, recomputes the sum and reports done/pass/error statistics.
module moving_average3_stim_check
    import ma3_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 256,
    parameter int unsigned DUT_LATENCY = 1,
    parameter int unsigned WARMUP      = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    output sample_t     eta_i1,
    input  sample_t     topLet_o,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_idx
);

    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 65535) begin : g_bad_num_samples
        $error("NUM_SAMPLES must be within 1..65535");
    end
    if (DUT_LATENCY > 7) begin : g_bad_latency
        $error("DUT_LATENCY must be within 0..7");
    end

    localparam logic [SAMPLE_W-1:0] SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [IDX_W-1:0]    WARM_LAST  = IDX_W'(WARMUP - 1);
    localparam logic [IDX_W-1:0]    DRAIN_LAST = IDX_W'(DUT_LATENCY - 1);
    localparam int unsigned         CHK_W      = $bits(chk_t);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SAMPLE_W-1:0]   lfsr_q, lfsr_d;
    sample_t               eta_d;
    logic                  eta_vld_q, eta_vld_d;
    sample_t               x1_q, x2_q;
    logic                  done_d, pass_d;
    logic [15:0]           err_d, first_d;

    chk_t                  exp_c, dly_c;
    logic [CHK_W-1:0]      dly_data_c;
    logic                  dly_vld_c;
    logic                  mismatch_c;

    // State register
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, stimulus and comparison bookkeeping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lfsr_d    = lfsr_q;
        eta_d     = '0;
        eta_vld_d = 1'b0;
        err_d     = err_cnt;
        first_d   = first_err_idx;
        done_d    = done;
        pass_d    = pass;

        case (state_q)
            WAIT: begin
                if (WARMUP == 0 || cnt_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = (DUT_LATENCY == 0) ? DONE : DRAIN;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT;
            end
        endcase

        // A fresh sample is presented in every cycle spent in RUN
        if (state_d == RUN) begin
            lfsr_d    = lfsr_step(lfsr_q);
            eta_d     = sample_t'(lfsr_d);
            eta_vld_d = 1'b1;
        end

        if (mismatch_c) begin
            if (err_cnt != 16'hFFFF) begin
                err_d = err_cnt + 16'd1;
            end
            if (first_err_idx == IDX_NONE) begin
                first_d = dly_c.idx;
            end
        end

        if (state_d == DONE) begin
            done_d = 1'b1;
            pass_d = (err_d == 16'd0);
        end
    end

    // Datapath registers, model history and outputs
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            lfsr_q        <= SEED;
            eta_i1        <= '0;
            eta_vld_q     <= 1'b0;
            x1_q          <= '0;
            x2_q          <= '0;
            err_cnt       <= '0;
            first_err_idx <= IDX_NONE;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            lfsr_q        <= lfsr_d;
            eta_i1        <= eta_d;
            eta_vld_q     <= eta_vld_d;
            x1_q          <= eta_i1;
            x2_q          <= x1_q;
            err_cnt       <= err_d;
            first_err_idx <= first_d;
            done          <= done_d;
            pass          <= pass_d;
        end
    end

    always_comb begin
        exp_c     = '0;
        exp_c.idx = idx_q;
        exp_c.exp = ma3_sum(eta_i1, x1_q, x2_q);
    end

    ma3_delay_line #(
        .W     (CHK_W),
        .DEPTH (DUT_LATENCY)
    ) u_align (
        .clk       (system1000),
        .rst_n     (system1000_rstn),
        .in_valid  (eta_vld_q),
        .in_data   (exp_c),
        .out_valid (dly_vld_c),
        .out_data  (dly_data_c)
    );

    // X/Z on the DUT output is treated as a mismatch
    always_comb begin
        dly_c      = chk_t'(dly_data_c);
        mismatch_c = dly_vld_c && (topLet_o !== dly_c.exp);
    end

endmodule

// File: tb/tb_moving_average3_stim_check.sv
// Bench: six checker instances against good, broken and delayed DUT models, with a mid-run reset.
module tb_moving_average3_stim_check;
    import ma3_pkg::*;

    localparam int unsigned NI = 6;
    // DUT kinds: 0 registered sum, 1 x0+x1 only, 2 sum plus an extra register, 3 combinational sum
    localparam int unsigned KIND  [NI] = '{0, 1, 2, 2, 3, 0};
    localparam int unsigned LAT   [NI] = '{1, 1, 2, 1, 0, 1};
    localparam int unsigned NS    [NI] = '{256, 256, 256, 256, 256, 1};
    localparam logic [7:0]  SEEDS [NI] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};

    localparam logic        E_PASS [NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [15:0] E_ERR  [NI] = '{16'd0, 16'd254, 16'd0, 16'd256, 16'd0, 16'd0};
    localparam logic [15:0] E_FIDX [NI] = '{16'hFFFF, 16'd2, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF};
    localparam int unsigned E_DCYC [NI] = '{259, 259, 260, 259, 258, 4};

    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [15:0] fidx;
        int unsigned dcyc;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    sample_t       eta_a  [NI];
    logic [NI-1:0] done_a;
    logic [NI-1:0] pass_a;
    logic [15:0]   err_a  [NI];
    logic [15:0]   fidx_a [NI];

    int unsigned   cyc;
    int unsigned   done_cyc [NI];
    int            checks = 0;
    int            errors = 0;
    int unsigned   seen   = 0;
    logic [7:0]    stim_q [$];
    res_t          res_q  [$];
    logic          run2;
    logic          mon_done;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        sample_t     eta_w, top_w, h1, h2, r1, r2;
        logic        done_w, pass_w;
        logic [15:0] err_w, fidx_w;

        moving_average3_stim_check #(
            .NUM_SAMPLES (NS[g]),
            .DUT_LATENCY (LAT[g]),
            .WARMUP      (2),
            .LFSR_SEED   (SEEDS[g])
        ) u_dut (
            .system1000      (clk),
            .system1000_rstn (rst_n),
            .eta_i1          (eta_w),
            .topLet_o        (top_w),
            .done            (done_w),
            .pass            (pass_w),
            .err_cnt         (err_w),
            .first_err_idx   (fidx_w)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                {h1, h2, r1, r2} <= '0;
            end else begin
                h1 <= eta_w;
                h2 <= h1;
                r1 <= (KIND[g] == 1) ? sample_t'(eta_w + h1) : ma3_sum(eta_w, h1, h2);
                r2 <= r1;
            end
        end

        always_comb begin
            case (KIND[g])
                2:       top_w = r2;
                3:       top_w = ma3_sum(eta_w, h1, h2);
                default: top_w = r1;
            endcase
        end

        assign eta_a[g]  = eta_w;
        assign done_a[g] = done_w;
        assign pass_a[g] = pass_w;
        assign err_a[g]  = err_w;
        assign fidx_a[g] = fidx_w;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n)                           done_cyc[i] = 0;
            else if (done_a[i] && done_cyc[i] == 0) done_cyc[i] = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] s);
        logic [7:0] n;
        n = {1'b0, s[7:1]};
        if (s[0]) n = n ^ 8'hB8;
        return n;
    endfunction

    // Expected stimulus: hand-derived first samples from seed A5, then the polynomial onward
    task automatic load_stim();
        logic [7:0] s;
        logic [7:0] hand [6] = '{8'hEA, 8'h75, 8'h82, 8'h41, 8'h98, 8'h4C};
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(hand[i]);
        s = 8'h4C;
        for (int i = 6; i < 256; i++) begin
            s = lfsr_nxt(s);
            stim_q.push_back(s);
        end
    endtask

    // Stimulus monitor on instance 0; instance 5 checks seed-zero coercion
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && eta_a[0] != 0) begin
            if (stim_q.size() == 0) begin
                check("eta_extra", {24'd0, eta_a[0]}, 32'd0);
            end else begin
                e = stim_q.pop_front();
                check($sformatf("eta_s%0d", seen), {24'd0, eta_a[0]}, {24'd0, e});
                seen++;
            end
        end
        if (rst_n && cyc == 2) check("seed0_first", {24'd0, eta_a[5]}, 32'hB8);
    end

    // Result monitor: pops an expectation when each instance raises done
    initial begin
        res_t r;
        mon_done = 1'b0;
        wait (run2);
        for (int i = 0; i < NI; i++) begin
            r = res_q.pop_front();
            for (int n = 0; n < 600 && !done_a[i]; n++) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("inst%0d_done", i), {31'd0, done_a[i]}, 32'd1);
            check($sformatf("inst%0d_pass", i), {31'd0, pass_a[i]}, {31'd0, r.pass});
            check($sformatf("inst%0d_err", i), {16'd0, err_a[i]}, {16'd0, r.err});
            check($sformatf("inst%0d_fidx", i), {16'd0, fidx_a[i]}, {16'd0, r.fidx});
            check($sformatf("inst%0d_done_cycle", i), done_cyc[i], r.dcyc);
        end
        mon_done = 1'b1;
    end

    initial begin
        sample_t     neg;
        res_t        r;
        int unsigned seen_base;
        rst_n = 1'b0;
        run2  = 1'b0;
        neg   = 8'sh80;
        check("sum_wrap_pos", {24'd0, ma3_sum(8'sd127, 8'sd127, 8'sd127)}, 32'h7D);
        check("sum_wrap_neg", {24'd0, ma3_sum(neg, neg, neg)}, 32'h80);
        load_stim();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_eta%0d", i), {24'd0, eta_a[i]}, 32'd0);
            check($sformatf("rst_done%0d", i), {31'd0, done_a[i]}, 32'd0);
            check($sformatf("rst_fidx%0d", i), {16'd0, fidx_a[i]}, 32'hFFFF);
        end
        rst_n = 1'b1;

        // Abandon the first run while sample 100 is on the bus
        for (int n = 0; n < 300 && cyc != 102; n++) @(negedge clk);
        check("reach_sample100", cyc, 32'd102);
        check("mid_done0", {31'd0, done_a[0]}, 32'd0);
        check("mid_done5", {31'd0, done_a[5]}, 32'd1);
        check("mid_err1", {16'd0, err_a[1]}, 32'd97);
        check("mid_fidx1", {16'd0, fidx_a[1]}, 32'd2);
        check("mid_err3", {16'd0, err_a[3]}, 32'd99);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("arst_eta%0d", i), {24'd0, eta_a[i]}, 32'd0);
            check($sformatf("arst_done%0d", i), {31'd0, done_a[i]}, 32'd0);
            check($sformatf("arst_pass%0d", i), {31'd0, pass_a[i]}, 32'd0);
            check($sformatf("arst_err%0d", i), {16'd0, err_a[i]}, 32'd0);
            check($sformatf("arst_fidx%0d", i), {16'd0, fidx_a[i]}, 32'hFFFF);
        end

        repeat (2) @(negedge clk);
        load_stim();
        seen_base = seen;
        for (int i = 0; i < NI; i++) begin
            r.pass = E_PASS[i];
            r.err  = E_ERR[i];
            r.fidx = E_FIDX[i];
            r.dcyc = E_DCYC[i];
            res_q.push_back(r);
        end
        run2  = 1'b1;
        rst_n = 1'b1;

        for (int n = 0; n < 3000 && !mon_done; n++) @(negedge clk);
        check("monitor_finished", {31'd0, mon_done}, 32'd1);
        check("eta_sample_count", seen - seen_base, 32'd256);
        check("eta_queue_left", stim_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
